// File: rtl/exh_stim_seq.sv
// ============================================================================
// Module   : exh_stim_seq
// Brief    : Exhaustive stimulus sequencer for a 4-input combinational DUT.
//            Optional `SIG_CHECK_EN adds an expected-signature comparator.
// Revision : 1.0
// ============================================================================
`default_nettype none

module exh_stim_seq #(
    parameter int              A_W   = 1,
    parameter int              B_W   = 1,
    parameter int              C_W   = 2,
    parameter int              D_W   = 2,
    parameter int              F_W   = 3,
    parameter int              DWELL = 10,
    parameter int              SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY = 16'h1021,
    parameter logic [SIG_W-1:0] SEED = 16'hFFFF,
    localparam int             IW    = A_W + B_W + C_W + D_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [A_W-1:0]   stim_a,
    output logic [B_W-1:0]   stim_b,
    output logic [C_W-1:0]   stim_c,
    output logic [D_W-1:0]   stim_d,
    input  logic [F_W-1:0]   dut_f,
`ifdef SIG_CHECK_EN
    input  logic [SIG_W-1:0] exp_sig,
    output logic             pass,
    output logic             fail,
`endif
    output logic             busy,
    output logic             done,
    output logic             sample_stb,
    output logic [IW-1:0]    vec_idx,
    output logic [SIG_W-1:0] sig
);

    localparam int            CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DWELL - 1);
    localparam logic [IW-1:0] LAST_IDX = '1;

    generate
        if (DWELL < 1) begin : g_dwell_chk
            $error("exh_stim_seq: DWELL must be >= 1");
        end
        if (F_W > SIG_W) begin : g_fw_chk
            $error("exh_stim_seq: F_W must be <= SIG_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DWELL  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [IW-1:0]    vec_idx_q;
    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;
    logic             busy_q;
    logic             done_q;
    logic             stb_q;
`ifdef SIG_CHECK_EN
    logic             pass_q;
    logic             fail_q;
`endif

    always_comb begin
        sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ SIG_W'(dut_f);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            vec_idx_q <= '0;
            sig_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            stb_q     <= 1'b0;
`ifdef SIG_CHECK_EN
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
`endif
        end else begin
            stb_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (abort) begin
`ifdef SIG_CHECK_EN
                        pass_q <= 1'b0;
                        fail_q <= 1'b0;
`endif
                    end else if (start) begin
                        state_q   <= S_DWELL;
                        vec_idx_q <= '0;
                        cnt_q     <= CNT_LOAD;
                        sig_q     <= SEED;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
`ifdef SIG_CHECK_EN
                        pass_q    <= 1'b0;
                        fail_q    <= 1'b0;
`endif
                    end
                end
                S_DWELL: begin
                    if (abort) begin
                        state_q   <= S_IDLE;
                        vec_idx_q <= '0;
                        busy_q    <= 1'b0;
                    end else if (cnt_q == '0) begin
                        state_q <= S_SAMPLE;
                        stb_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_SAMPLE: begin
                    // An abort here discards the pending capture.
                    if (abort) begin
                        state_q   <= S_IDLE;
                        vec_idx_q <= '0;
                        busy_q    <= 1'b0;
                    end else begin
                        sig_q <= sig_d;
                        if (vec_idx_q == LAST_IDX) begin
                            state_q   <= S_DONE;
                            vec_idx_q <= '0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
`ifdef SIG_CHECK_EN
                            pass_q    <= (sig_d == exp_sig);
                            fail_q    <= (sig_d != exp_sig);
`endif
                        end else begin
                            state_q   <= S_DWELL;
                            vec_idx_q <= vec_idx_q + 1'b1;
                            cnt_q     <= CNT_LOAD;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Stimulus tracks vec_idx, which is already zero outside a run.
    assign {stim_d, stim_c, stim_b, stim_a} = vec_idx_q;

    assign busy       = busy_q;
    assign done       = done_q;
    assign sample_stb = stb_q;
    assign vec_idx    = vec_idx_q;
    assign sig        = sig_q;
`ifdef SIG_CHECK_EN
    assign pass       = pass_q;
    assign fail       = fail_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_exh_stim_seq.sv
// ============================================================================
// Module   : tb_exh_stim_seq
// Brief    : Directed self-checking bench for exh_stim_seq (default and DWELL=1).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_exh_stim_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [0:0]  stim_a, stim_b;
    logic [1:0]  stim_c, stim_d;
    logic [2:0]  dut_f;
    logic        busy, done, sample_stb;
    logic [5:0]  vec_idx;
    logic [15:0] sig;
`ifdef SIG_CHECK_EN
    logic [15:0] exp_sig = 16'h0;
    logic        pass, fail;
    logic [15:0] exp_sig1 = 16'h0;
    logic        pass1, fail1;
`endif

    logic        start1 = 1'b0;
    logic [0:0]  s1_a, s1_b;
    logic [1:0]  s1_c, s1_d;
    logic [2:0]  f1;
    logic        busy1, done1, stb1;
    logic [5:0]  idx1;
    logic [15:0] sig1;

    logic [3:0]  w_sum, w_sum1;
    assign w_sum  = {3'b0, stim_a} + {3'b0, stim_b} + {2'b0, stim_c} + {2'b0, stim_d};
    assign dut_f  = w_sum[2:0];
    assign w_sum1 = {3'b0, s1_a} + {3'b0, s1_b} + {2'b0, s1_c} + {2'b0, s1_d};
    assign f1     = w_sum1[2:0];

    always #5 clk = ~clk;

    exh_stim_seq u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .stim_a(stim_a), .stim_b(stim_b), .stim_c(stim_c), .stim_d(stim_d),
        .dut_f(dut_f),
`ifdef SIG_CHECK_EN
        .exp_sig(exp_sig), .pass(pass), .fail(fail),
`endif
        .busy(busy), .done(done), .sample_stb(sample_stb),
        .vec_idx(vec_idx), .sig(sig)
    );

    exh_stim_seq #(.DWELL(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0),
        .stim_a(s1_a), .stim_b(s1_b), .stim_c(s1_c), .stim_d(s1_d),
        .dut_f(f1),
`ifdef SIG_CHECK_EN
        .exp_sig(exp_sig1), .pass(pass1), .fail(fail1),
`endif
        .busy(busy1), .done(done1), .sample_stb(stb1),
        .vec_idx(idx1), .sig(sig1)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference MISR: signature after n samples of f = A+B+C+D (3-bit wrap).
    function automatic logic [15:0] model_sig(input int n);
        logic [15:0] s;
        logic [5:0]  v;
        logic [3:0]  f;
        s = 16'hFFFF;
        for (int k = 0; k < n; k++) begin
            v = k[5:0];
            f = {3'b0, v[0]} + {3'b0, v[1]} + {2'b0, v[3:2]} + {2'b0, v[5:4]};
            s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {13'b0, f[2:0]};
        end
        return s;
    endfunction

    // Start a run on the default instance and follow it until busy drops.
    task automatic run(input int abort_idx, input int extra_start,
                       output int busy_cyc, output int pulses, output int bad,
                       output bit aborted);
        aborted = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", {31'b0, busy}, 32'd1);
        check("start_idx", {26'b0, vec_idx}, 32'd0);
        check("start_sig", {16'b0, sig}, 32'hFFFF);
        busy_cyc = 1;
        pulses   = 0;
        bad      = 0;
        for (int cyc = 1; cyc < 2000 && busy; cyc++) begin
            if ({stim_d, stim_c, stim_b, stim_a} != vec_idx) bad++;
            if (sample_stb) begin
                if (vec_idx != 6'(pulses)) bad++;
                pulses++;
            end
            if (abort_idx >= 0 && vec_idx == 6'(abort_idx) && !sample_stb) abort = 1'b1;
            if (cyc == extra_start) start = 1'b1;
            tick();
            start = 1'b0;
            if (abort) begin
                abort   = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (busy) busy_cyc++;
        end
    endtask

    initial begin
        int  bc, np, bad;
        bit  ab;
        logic [15:0] sig_hold;

        #12;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_stb", {31'b0, sample_stb}, 32'd0);
        check("rst_idx", {26'b0, vec_idx}, 32'd0);
        check("rst_sig", {16'b0, sig}, 32'd0);
        check("rst_stim", {26'b0, stim_d, stim_c, stim_b, stim_a}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Full run with a stray start at cycle 50.
`ifdef SIG_CHECK_EN
        exp_sig = model_sig(64);
`endif
        run(-1, 50, bc, np, bad, ab);
        check("full_busy_cycles", bc, 704);
        check("full_pulses", np, 64);
        check("full_order", bad, 0);
        check("full_done", {31'b0, done}, 32'd1);
        check("full_sig", {16'b0, sig}, {16'b0, model_sig(64)});
        check("full_stim_zero", {26'b0, stim_d, stim_c, stim_b, stim_a}, 32'd0);
`ifdef SIG_CHECK_EN
        check("chk_pass", {31'b0, pass}, 32'd1);
        check("chk_fail", {31'b0, fail}, 32'd0);
`endif

        // start together with abort in DONE: nothing happens.
        sig_hold = sig;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        tick();
        check("sa_done_held", {31'b0, done}, 32'd1);
        check("sa_no_busy", {31'b0, busy}, 32'd0);
        check("sa_sig_held", {16'b0, sig}, {16'b0, sig_hold});

        // Abort during DWELL of vector 17.
        run(17, -1, bc, np, bad, ab);
        check("abort_taken", {31'b0, ab}, 32'd1);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_stim", {26'b0, stim_d, stim_c, stim_b, stim_a}, 32'd0);
        check("abort_pulses", np, 17);
        check("abort_sig", {16'b0, sig}, {16'b0, model_sig(17)});
        tick();
        check("abort_sig_stable", {16'b0, sig}, {16'b0, model_sig(17)});

        // Restart; with the checker, expect a miscompare.
`ifdef SIG_CHECK_EN
        exp_sig = model_sig(64) ^ 16'h0001;
`endif
        run(-1, -1, bc, np, bad, ab);
        check("rerun_busy_cycles", bc, 704);
        check("rerun_order", bad, 0);
        check("rerun_sig", {16'b0, sig}, {16'b0, model_sig(64)});
`ifdef SIG_CHECK_EN
        check("chk_pass_bad", {31'b0, pass}, 32'd0);
        check("chk_fail_bad", {31'b0, fail}, 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("chk_pass_clr", {31'b0, pass}, 32'd0);
        check("chk_fail_clr", {31'b0, fail}, 32'd0);
`else
        start = 1'b1;
        tick();
        start = 1'b0;
`endif

        // Asynchronous reset mid-run (run already started above).
        repeat (299) tick();
        check("mid_busy_pre", {31'b0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_idx", {26'b0, vec_idx}, 32'd0);
        check("mid_rst_sig", {16'b0, sig}, 32'd0);
        check("mid_rst_stim", {26'b0, stim_d, stim_c, stim_b, stim_a}, 32'd0);
        #3;
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_idle", {30'b0, busy, done}, 32'd0);

        // DWELL=1 instance.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        bc  = 0;
        np  = 0;
        bad = 0;
        for (int cyc = 1; cyc < 400 && busy1; cyc++) begin
            bc++;
            if (stb1 != ((cyc % 2) == 0)) bad++;
            if ({s1_d, s1_c, s1_b, s1_a} != 6'((cyc - 1) / 2)) bad++;
            if (stb1) np++;
            tick();
        end
        check("d1_busy_cycles", bc, 128);
        check("d1_pulses", np, 64);
        check("d1_pattern", bad, 0);
        check("d1_done", {31'b0, done1}, 32'd1);
        check("d1_sig", {16'b0, sig1}, {16'b0, model_sig(64)});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/exh_stim_seq.md
Name: exh_stim_seq

Overview:
Hardware stimulus sequencer for small combinational DUTs with four operand inputs (A, B, C, D) and one result F. On start it drives every input combination exhaustively, holds each vector for a programmable dwell time, samples F, and folds it into a MISR signature. It replaces free-running #10 stimulus with a synthesizable, clocked controller usable in simulation benches and on-chip self-test wrappers.

Parameters:
A_W, 1, width of stim_a
B_W, 1, width of stim_b
C_W, 2, width of stim_c
D_W, 2, width of stim_d
F_W, 3, width of dut_f; must be <= SIG_W
DWELL, 10, cycles each vector is held before sampling; >= 1, 0 is an elaboration error
SIG_W, 16, MISR width
POLY, 16'h1021, MISR feedback polynomial
SEED, 16'hFFFF, MISR value loaded on start

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin sequence; sampled only in IDLE or DONE
abort  in  1  terminate sequence; priority over start
stim_a  out  A_W  DUT input A
stim_b  out  B_W  DUT input B
stim_c  out  C_W  DUT input C
stim_d  out  D_W  DUT input D
dut_f  in  F_W  DUT result
busy  out  1  sequence in progress
done  out  1  sequence completed; level, held until next start
sample_stb  out  1  one-cycle pulse when dut_f is captured
vec_idx  out  IW  current vector index, IW = A_W+B_W+C_W+D_W
sig  out  SIG_W  MISR signature

Behaviour:
- Reset (async, rst_n=0): state IDLE; all stim_* = 0; busy=0, done=0, sample_stb=0, vec_idx=0, sig=0.
- Vector ordering: {stim_d, stim_c, stim_b, stim_a} = vec_idx. A toggles fastest, D slowest. N = 2^IW vectors (64 at defaults).
- States: IDLE, DWELL, SAMPLE, DONE.
- IDLE/DONE, start=1, abort=0: next state DWELL; vec_idx=0; dwell counter=DWELL-1; sig=SEED; busy=1; done=0.
- DWELL: stim_* driven from vec_idx. Counter decrements each cycle. At 0, go to SAMPLE. Vector held for exactly DWELL cycles.
- SAMPLE (1 cycle): sample_stb=1.
  - sig <= {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zero-extended dut_f.
  - If vec_idx==N-1: go to DONE; stim_*=0; vec_idx=0; busy=0; done=1.
  - Otherwise: vec_idx+1, counter reloaded, return to DWELL.
- Timing: each vector takes DWELL+1 cycles. busy is high for exactly N*(DWELL+1) cycles (704 at defaults). done rises on the same edge busy falls.
- sig is stable whenever busy=0.
- abort=1 in DWELL or SAMPLE: next state IDLE; stim_*=0; busy=0; done stays 0; vec_idx=0; sig holds its last value. No sample occurs in that cycle.
- start while busy: ignored.
- start and abort in the same cycle in IDLE/DONE: abort wins, no run starts, done unchanged.
- Counter widths are sized with $clog2(DWELL). vec_idx has no wrap-around inside a run; termination is by compare against N-1.

Optional Feature:
SIG_CHECK_EN.
- Defined: adds input exp_sig [SIG_W] and outputs pass, fail (1 bit each, reset 0).
  - On entry to DONE: pass = (sig_next==exp_sig), fail = ~pass.
  - Both cleared on start or abort.
- Undefined: these ports and the comparator are absent; behaviour is otherwise identical.

Test Plan:
- Reset mid-run: assert rst_n=0 at cycle 300 of a run -> all outputs 0 immediately, before the next clock edge. After release, state is IDLE.
- Full run, defaults, bench model dut_f = A+B+C+D: start pulse ->
  - busy high for 704 cycles; done rises at cycle 704;
  - 64 sample_stb pulses with vec_idx 0..63 in order;
  - at pulse k, {D,C,B,A} == k;
  - final sig equals the bench MISR model; stim_*=0 after done.
- DWELL=1 parameterisation -> 128 busy cycles; stim changes every 2 cycles; sample_stb high on every second cycle.
- abort at vec_idx=17 during DWELL -> next cycle busy=0, done=0, stim_*=0. sig equals the model after 17 samples. A subsequent start restarts at vec_idx=0 with sig=SEED.
- Start while busy at cycle 50 -> no effect, run completes normally. start+abort together in DONE -> done stays 1, no new run.
- SIG_CHECK_EN defined:
  - exp_sig = model signature -> pass=1, fail=0 at done.
  - exp_sig with bit 0 flipped -> pass=0, fail=1.
  - Both cleared on the next start.
